sram_bank_sequencer: RTL and testbench
======================================

# sram_bank_sequencer

Phase-driven controller for the two-read-port SRAM bank. Two requesters issue read/write requests; the block arbitrates once per Bennett cycle, then drives the bank's word lines, write data, ReadEn, WriteEn and the sram clock pair at the phases the bank expects. Read data is returned per requester. It sits between the core's memory clients and the bank, slaved to the 10-phase Bennett clock.

## Interface
- WIDTH, 16, data width of the bank
- ROWS, 32, number of word lines; one-hot word bus width
- AW, 5, request address width; addresses ≥ ROWS are illegal
- clk  in  1  system clock; the Bennett clock generator runs on the same clock
- reset  in  1  asynchronous, active-high
- clkp  in  10  Bennett phase vector; phase k is active when clkp[k] is high
- Mclk  in  1  master ramp from the Bennett clock, used only for srclk generation
- req_valid  in  2  per-requester request valid (index 0 = port A, 1 = port B)
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2×AW  row address per requester
- req_wdata  in  2×WIDTH  write data per requester
- req_ready  out  2  one-clk grant pulse; the request is consumed on it
- rsp_valid  out  2  one-clk pulse: read data valid
- rsp_rdata  out  2×WIDTH  captured read data, held until the next capture
- wordA, wordB  out  ROWS  one-hot word lines to the bank
- ReadEn, WriteEn  out  1  bank enables
- din  out  WIDTH  bank write data
- outA, outB  in  WIDTH  bank read data
- srclkneg, srclkpos  out  1  sram clock pair

## Operation
- Phase events: rise of clkp[k] is detected when clkp[k]=1 and its registered copy is 0. All outputs except srclk are registered, so they change 1 clk after the rise is sampled.
- FSM: IDLE → (rise clkp[0]) ARB → ADDR → (rise clkp[2]) DATA → (rise clkp[4]) ACCESS → (rise clkp[6]/[8]) RETIRE → (rise clkp[9]) IDLE.
- ARB occurs on the rise of clkp[0]. It samples req_valid and pulses req_ready for the winners. If there are no requests, the block sits out the cycle in IDLE with all outputs at their reset values.
- Arbitration:
  - Two reads: both are granted. Port 0 goes to wordA, port 1 to wordB.
  - A single request of either kind is granted.
  - Write+read, write+write: only one is granted, chosen by a round-robin pointer. The pointer toggles only when a conflict is resolved. On reset it favours port 0.
- A write drives both wordA and wordB to the same one-hot row.
- ADDR: at rise clkp[2], drive wordA/wordB. An unused port's word line stays 0.
- DATA: at rise clkp[4], drive din with the granted write data. din is 0 for read cycles.
- Read: ReadEn=1 from rise clkp[6] to rise clkp[8].
- Write: WriteEn=1 from rise clkp[8] to rise clkp[9].
- RETIRE, at rise clkp[9]:
  - For each granted read, capture outA/outB into rsp_rdata and pulse rsp_valid.
  - Clear the word lines and din.
- Illegal address (≥ ROWS): the request is granted, but its word line stays all-zero. A read returns rsp_valid with rdata 0.
- srclkneg = (Mclk ^ clkp[6]) & clkp[6], combinational; srclkpos = ~srclkneg.
- Reset, including mid-cycle: all registered outputs are 0 immediately, in-flight ops are dropped with no rsp_valid, the FSM goes to IDLE and the RR pointer resets. Operation resumes at the next clkp[0] rise.

## Timing
- Grant latency: req_ready occurs 1 clk after the clkp[0] rise is sampled. Requests not granted must stay asserted until they are granted.
- Read latency: rsp_valid occurs 1 clk after the clkp[9] rise of the same Bennett cycle.
- At most one Bennett cycle is in flight. Requests presented mid-cycle wait for the next clkp[0] rise.
- ReadEn and WriteEn are never high together. A rise of clkp[k] that is out of FSM order is ignored.

## Structure
- A shared package holds phase index constants (PH_ARB=0, PH_ADDR=2, PH_DATA=4, PH_RD=6, PH_WR=8, PH_RET=9), the FSM state enum and the op-type enum.
- One sub-module, phase_edge_detect: registers clkp and outputs a 10-bit rise vector.

## Test plan
- Single write: port 0 writes addr 3, data 16'hAAAA.
  - req_ready[0] pulses 1 clk after the clkp[0] rise.
  - wordA = wordB = 32'h8 from ph2.
  - din = 16'hAAAA from ph4.
  - WriteEn=1 from ph8 to ph9.
  - No rsp_valid.
- Dual read: port 0 reads addr 3, port 1 reads addr 1 after the write above.
  - wordA = 32'h8, wordB = 32'h2.
  - ReadEn=1 from ph6 to ph8.
  - At ph9, rsp_valid = 2'b11, with rsp_rdata[0] = 16'hAAAA.
- Write/write conflict: port 0 writes row 4 (16'h1111) and port 1 writes row 5 (16'h2222) in the same cycle.
  - Port 0 is granted first.
  - Port 1 is granted in the next Bennett cycle.
  - Read-back returns both values.
- Read/write conflict with the RR pointer at port 1: port 0 reads and port 1 writes.
  - The port 1 write goes first.
  - The port 0 read occurs in the next cycle.
- Illegal address 31 with ROWS=16: word lines stay 0, rsp_valid occurs with rdata 0.
- Reset asserted between ph6 and ph8 of a read:
  - ReadEn, the word lines and din fall to 0 immediately.
  - No rsp_valid.
  - The next request is serviced normally.

Source files
------------

// File: rtl/sram_bank_sequencer_pkg.sv
// Shared definitions for the SRAM bank sequencer: Bennett phase indices,
// sequencer states, operation types and the two-port arbitration helper.
package sram_bank_sequencer_pkg;

   localparam int NUM_PH  = 10;
   localparam int PH_ARB  = 0;
   localparam int PH_ADDR = 2;
   localparam int PH_DATA = 4;
   localparam int PH_RD   = 6;
   localparam int PH_WR   = 8;
   localparam int PH_RET  = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_ADDR,
      ST_DATA,
      ST_ACCESS,
      ST_RETIRE
   } seq_state_e;

   typedef enum logic [1:0] {
      OP_NONE,
      OP_READ,
      OP_WRITE
   } op_type_e;

   typedef struct packed {
      logic [1:0] grant;
      logic       toggle_rr;
   } arb_result_t;

   // Two reads share the bank; anything involving a write is serialised by
   // the round-robin pointer, which only advances when it breaks a tie.
   function automatic arb_result_t arbitrate(input logic [1:0] valid,
                                             input logic [1:0] write,
                                             input logic       rr_ptr);
      arb_result_t res;
      res.grant     = valid;
      res.toggle_rr = 1'b0;
      if (valid == 2'b11 && write != 2'b00) begin
         res.grant     = rr_ptr ? 2'b10 : 2'b01;
         res.toggle_rr = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_bank_sequencer_phase_edge_detect.sv
// Rising-edge detector for the Bennett phase vector: a phase rises when it
// is high now and was low on the previous clk.
module sram_bank_sequencer_phase_edge_detect
   import sram_bank_sequencer_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NUM_PH-1:0] i_clkp,
   output logic [NUM_PH-1:0] o_rise
);

   logic [NUM_PH-1:0] r_clkp_q;

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_clkp_q <= '0;
      else         r_clkp_q <= i_clkp;
   end

   assign o_rise = i_clkp & ~r_clkp_q;

endmodule

// File: rtl/sram_bank_sequencer.sv
// Phase-driven sequencer for the two-read-port SRAM bank: arbitrates two
// requesters once per Bennett cycle and drives the bank at the expected phases.
module sram_bank_sequencer
   import sram_bank_sequencer_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ROWS  = 32,
   parameter int AW    = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PH-1:0]    clkp,
   input  logic                 Mclk,
   input  logic [1:0]           req_valid,
   input  logic [1:0]           req_write,
   input  logic [2*AW-1:0]      req_addr,
   input  logic [2*WIDTH-1:0]   req_wdata,
   output logic [1:0]           req_ready,
   output logic [1:0]           rsp_valid,
   output logic [2*WIDTH-1:0]   rsp_rdata,
   output logic [ROWS-1:0]      wordA,
   output logic [ROWS-1:0]      wordB,
   output logic                 ReadEn,
   output logic                 WriteEn,
   output logic [WIDTH-1:0]     din,
   input  logic [WIDTH-1:0]     outA,
   input  logic [WIDTH-1:0]     outB,
   output logic                 srclkneg,
   output logic                 srclkpos
);

   function automatic logic [ROWS-1:0] row_onehot(input logic [AW-1:0] addr);
      logic [ROWS-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         if (int'(addr) == r) v[r] = 1'b1;
      return v;
   endfunction

   function automatic logic row_legal(input logic [AW-1:0] addr);
      return int'(addr) < ROWS;
   endfunction

   logic [NUM_PH-1:0] w_rise;
   logic              w_unused_rise;

   sram_bank_sequencer_phase_edge_detect u_phase_edge_detect (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clkp  (clkp),
      .o_rise  (w_rise)
   );

   assign w_unused_rise = ^{w_rise[1], w_rise[3], w_rise[5], w_rise[7]};

   seq_state_e         r_state,     w_state_nxt;
   logic               r_rr_ptr,    w_rr_nxt;
   logic [1:0]         r_gnt,       w_gnt_nxt;
   op_type_e           r_op,        w_op_nxt;
   logic [AW-1:0]      r_addr_a,    w_addr_a_nxt;
   logic [AW-1:0]      r_addr_b,    w_addr_b_nxt;
   logic [WIDTH-1:0]   r_wdata,     w_wdata_nxt;
   logic [1:0]         r_req_ready, w_req_ready_nxt;
   logic [1:0]         r_rsp_valid, w_rsp_valid_nxt;
   logic [2*WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic [ROWS-1:0]    r_word_a,    w_word_a_nxt;
   logic [ROWS-1:0]    r_word_b,    w_word_b_nxt;
   logic               r_read_en,   w_read_en_nxt;
   logic               r_write_en,  w_write_en_nxt;
   logic [WIDTH-1:0]   r_din,       w_din_nxt;
   arb_result_t        w_arb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= 1'b0;
         r_gnt       <= '0;
         r_op        <= OP_NONE;
         r_addr_a    <= '0;
         r_addr_b    <= '0;
         r_wdata     <= '0;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_word_a    <= '0;
         r_word_b    <= '0;
         r_read_en   <= 1'b0;
         r_write_en  <= 1'b0;
         r_din       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_nxt;
         r_gnt       <= w_gnt_nxt;
         r_op        <= w_op_nxt;
         r_addr_a    <= w_addr_a_nxt;
         r_addr_b    <= w_addr_b_nxt;
         r_wdata     <= w_wdata_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_word_a    <= w_word_a_nxt;
         r_word_b    <= w_word_b_nxt;
         r_read_en   <= w_read_en_nxt;
         r_write_en  <= w_write_en_nxt;
         r_din       <= w_din_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      w_state_nxt     = r_state;
      w_rr_nxt        = r_rr_ptr;
      w_gnt_nxt       = r_gnt;
      w_op_nxt        = r_op;
      w_addr_a_nxt    = r_addr_a;
      w_addr_b_nxt    = r_addr_b;
      w_wdata_nxt     = r_wdata;
      w_req_ready_nxt = '0;
      w_rsp_valid_nxt = '0;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_word_a_nxt    = r_word_a;
      w_word_b_nxt    = r_word_b;
      w_read_en_nxt   = r_read_en;
      w_write_en_nxt  = r_write_en;
      w_din_nxt       = r_din;
      w_arb           = arbitrate(req_valid, req_write, r_rr_ptr);

      unique case (r_state)
         ST_IDLE: begin
            if (w_rise[PH_ARB] && w_arb.grant != 2'b00) begin
               w_state_nxt     = ST_ARB;
               w_req_ready_nxt = w_arb.grant;
               w_gnt_nxt       = w_arb.grant;
               if (w_arb.toggle_rr) w_rr_nxt = ~r_rr_ptr;
               if ((w_arb.grant & req_write) != 2'b00) begin
                  // A write owns both word lines; only one port can be granted here.
                  w_op_nxt     = OP_WRITE;
                  w_addr_a_nxt = w_arb.grant[1] ? req_addr[AW +: AW] : req_addr[0 +: AW];
                  w_addr_b_nxt = w_addr_a_nxt;
                  w_wdata_nxt  = w_arb.grant[1] ? req_wdata[WIDTH +: WIDTH]
                                                : req_wdata[0 +: WIDTH];
               end else begin
                  w_op_nxt     = OP_READ;
                  w_addr_a_nxt = req_addr[0 +: AW];
                  w_addr_b_nxt = req_addr[AW +: AW];
                  w_wdata_nxt  = '0;
               end
            end
         end
         ST_ARB: w_state_nxt = ST_ADDR;
         ST_ADDR: begin
            if (w_rise[PH_ADDR]) begin
               w_state_nxt  = ST_DATA;
               w_word_a_nxt = (r_op == OP_WRITE || r_gnt[0]) ? row_onehot(r_addr_a) : '0;
               w_word_b_nxt = (r_op == OP_WRITE || r_gnt[1]) ? row_onehot(r_addr_b) : '0;
            end
         end
         ST_DATA: begin
            if (w_rise[PH_DATA]) begin
               w_state_nxt = ST_ACCESS;
               w_din_nxt   = (r_op == OP_WRITE) ? r_wdata : '0;
            end
         end
         ST_ACCESS: begin
            if (w_rise[PH_WR]) begin
               w_state_nxt    = ST_RETIRE;
               w_read_en_nxt  = 1'b0;
               w_write_en_nxt = (r_op == OP_WRITE);
            end else if (w_rise[PH_RD]) begin
               w_read_en_nxt = (r_op == OP_READ);
            end
         end
         ST_RETIRE: begin
            if (w_rise[PH_RET]) begin
               w_state_nxt    = ST_IDLE;
               w_write_en_nxt = 1'b0;
               w_word_a_nxt   = '0;
               w_word_b_nxt   = '0;
               w_din_nxt      = '0;
               w_op_nxt       = OP_NONE;
               w_gnt_nxt      = '0;
               if (r_op == OP_READ) begin
                  // The bank output floats when no word line is driven, so illegal rows return 0.
                  if (r_gnt[0]) begin
                     w_rsp_valid_nxt[0]           = 1'b1;
                     w_rsp_rdata_nxt[0 +: WIDTH]  = row_legal(r_addr_a) ? outA : '0;
                  end
                  if (r_gnt[1]) begin
                     w_rsp_valid_nxt[1]              = 1'b1;
                     w_rsp_rdata_nxt[WIDTH +: WIDTH] = row_legal(r_addr_b) ? outB : '0;
                  end
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign wordA     = r_word_a;
   assign wordB     = r_word_b;
   assign ReadEn    = r_read_en;
   assign WriteEn   = r_write_en;
   assign din       = r_din;

   assign srclkneg = (Mclk ^ clkp[PH_RD]) & clkp[PH_RD];
   assign srclkpos = ~srclkneg;

endmodule

// File: tb/tb_sram_bank_sequencer.sv
// Directed bench for sram_bank_sequencer: one-hot Bennett phase generator,
// a small bank model, and hand-computed expectations per phase.
module tb_sram_bank_sequencer;

   localparam int WIDTH   = 16;
   localparam int ROWS    = 16;
   localparam int AW      = 5;
   localparam int PH_CLKS = 4;

   logic               clk;
   logic               reset;
   logic [9:0]         clkp;
   logic               Mclk;
   logic [1:0]         req_valid;
   logic [1:0]         req_write;
   logic [2*AW-1:0]    req_addr;
   logic [2*WIDTH-1:0] req_wdata;
   logic [1:0]         req_ready;
   logic [1:0]         rsp_valid;
   logic [2*WIDTH-1:0] rsp_rdata;
   logic [ROWS-1:0]    wordA;
   logic [ROWS-1:0]    wordB;
   logic               ReadEn;
   logic               WriteEn;
   logic [WIDTH-1:0]   din;
   logic [WIDTH-1:0]   outA;
   logic [WIDTH-1:0]   outB;
   logic               srclkneg;
   logic               srclkpos;

   int n_checks = 0;
   int n_pass   = 0;
   int ph;
   int ph_age;

   logic [WIDTH-1:0] mem [ROWS];

   sram_bank_sequencer #(.WIDTH(WIDTH), .ROWS(ROWS), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .clkp      (clkp),
      .Mclk      (Mclk),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .wordA     (wordA),
      .wordB     (wordB),
      .ReadEn    (ReadEn),
      .WriteEn   (WriteEn),
      .din       (din),
      .outA      (outA),
      .outB      (outB),
      .srclkneg  (srclkneg),
      .srclkpos  (srclkpos)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running one-hot Bennett phases, PH_CLKS clks each, changing on negedge.
   initial begin
      ph = 0; ph_age = 0; clkp = '0; Mclk = 1'b0;
      forever begin
         for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < PH_CLKS; j++) begin
               ph     = k;
               ph_age = j;
               clkp   = 10'(1) << k;
               Mclk   = (j >= 2);
               @(negedge clk);
            end
         end
      end
   end

   // Bank model; undriven word lines read back a recognisable float value.
   initial begin
      for (int r = 0; r < ROWS; r++) mem[r] = '0;
      forever begin
         @(posedge clk);
         if (WriteEn)
            for (int r = 0; r < ROWS; r++)
               if (wordA[r]) mem[r] = din;
      end
   end

   always_comb begin
      outA = '0;
      outB = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (wordA[r]) outA = outA | mem[r];
         if (wordB[r]) outB = outB | mem[r];
      end
      if (wordA == '0) outA = 16'hDEAD;
      if (wordB == '0) outB = 16'hBEEF;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Returns at the negedge one clk after phase k begins, when the DUT has reacted.
   task automatic sync_phase(input int k);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!(ph == k && ph_age == 0) && n < 200);
      if (!(ph == k && ph_age == 0)) begin
         n_checks++;
         $display("FAIL sync_ph%0d: phase start not seen within %0d clks", k, n);
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;

      sync_phase(3);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_words",     32'({wordA, wordB}), 32'h0);
      check("rst_enables",   32'({ReadEn, WriteEn}), 32'h0);
      check("rst_din",       32'(din), 32'h0);
      reset = 1'b0;

      // Single write: port 0, row 3, 16'hAAAA.
      sync_phase(9);
      req_valid = 2'b01; req_write = 2'b01;
      req_addr = {5'd0, 5'd3}; req_wdata = {16'h0000, 16'hAAAA};
      sync_phase(0);
      check("t1_ready", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      sync_phase(2);
      check("t1_wordA", 32'(wordA), 32'h8);
      check("t1_wordB", 32'(wordB), 32'h8);
      check("t1_srclkneg_ph2", 32'({srclkneg, srclkpos}), 32'h1);
      sync_phase(4);
      check("t1_din", 32'(din), 32'hAAAA);
      sync_phase(6);
      check("t1_en_ph6", 32'({ReadEn, WriteEn}), 32'h0);
      check("t1_srclkneg_ph6", 32'({srclkneg, srclkpos}), 32'h2);
      sync_phase(8);
      check("t1_en_ph8", 32'({ReadEn, WriteEn}), 32'h1);
      sync_phase(9);
      check("t1_en_ph9", 32'({ReadEn, WriteEn}), 32'h0);
      check("t1_rsp_valid", 32'(rsp_valid), 32'h0);
      check("t1_clear", 32'({wordA, wordB, din}), 32'h0);

      // Dual read: port 0 row 3, port 1 row 1.
      req_valid = 2'b11; req_write = 2'b00; req_addr = {5'd1, 5'd3};
      sync_phase(0);
      check("t2_ready", 32'(req_ready), 32'h3);
      req_valid = 2'b00;
      sync_phase(2);
      check("t2_wordA", 32'(wordA), 32'h8);
      check("t2_wordB", 32'(wordB), 32'h2);
      sync_phase(6);
      check("t2_en_ph6", 32'({ReadEn, WriteEn}), 32'h2);
      sync_phase(8);
      check("t2_en_ph8", 32'({ReadEn, WriteEn}), 32'h0);
      sync_phase(9);
      check("t2_rsp_valid", 32'(rsp_valid), 32'h3);
      check("t2_rdata0", 32'(rsp_rdata[0 +: WIDTH]), 32'hAAAA);
      check("t2_rdata1", 32'(rsp_rdata[WIDTH +: WIDTH]), 32'h0);
      @(negedge clk);
      check("t2_rsp_pulse", 32'(rsp_valid), 32'h0);
      check("t2_rdata0_hold", 32'(rsp_rdata[0 +: WIDTH]), 32'hAAAA);

      // Write/write conflict: port 0 row 4, port 1 row 5.
      req_valid = 2'b11; req_write = 2'b11;
      req_addr = {5'd5, 5'd4}; req_wdata = {16'h2222, 16'h1111};
      sync_phase(0);
      check("t3_ready_first", 32'(req_ready), 32'h1);
      req_valid = 2'b10;
      sync_phase(2);
      check("t3_words_first", 32'({wordA, wordB}), 32'h0010_0010);
      sync_phase(4);
      check("t3_din_first", 32'(din), 32'h1111);
      sync_phase(0);
      check("t3_ready_second", 32'(req_ready), 32'h2);
      req_valid = 2'b00;
      sync_phase(2);
      check("t3_words_second", 32'({wordA, wordB}), 32'h0020_0020);
      sync_phase(4);
      check("t3_din_second", 32'(din), 32'h2222);
      sync_phase(8);
      check("t3_wen_second", 32'({ReadEn, WriteEn}), 32'h1);
      sync_phase(9);
      req_valid = 2'b11; req_write = 2'b00; req_addr = {5'd5, 5'd4};
      sync_phase(0);
      check("t3_rb_ready", 32'(req_ready), 32'h3);
      req_valid = 2'b00;
      sync_phase(9);
      check("t3_rb_valid", 32'(rsp_valid), 32'h3);
      check("t3_rb_rdata", 32'(rsp_rdata), 32'h2222_1111);

      // Read/write conflict with the pointer at port 1: port 1 write wins.
      req_valid = 2'b11; req_write = 2'b10;
      req_addr = {5'd6, 5'd3}; req_wdata = {16'h3333, 16'h0000};
      sync_phase(0);
      check("t4_ready_write", 32'(req_ready), 32'h2);
      req_valid = 2'b01;
      sync_phase(2);
      check("t4_words_write", 32'({wordA, wordB}), 32'h0040_0040);
      sync_phase(8);
      check("t4_wen", 32'({ReadEn, WriteEn}), 32'h1);
      sync_phase(9);
      check("t4_no_rsp", 32'(rsp_valid), 32'h0);
      sync_phase(0);
      check("t4_ready_read", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      sync_phase(2);
      check("t4_words_read", 32'({wordA, wordB}), 32'h0008_0000);
      sync_phase(9);
      check("t4_rsp_valid", 32'(rsp_valid), 32'h1);
      check("t4_rdata0", 32'(rsp_rdata[0 +: WIDTH]), 32'hAAAA);

      // Illegal row 31 on port 1 (ROWS = 16).
      req_valid = 2'b10; req_write = 2'b00; req_addr = {5'd31, 5'd0};
      sync_phase(0);
      check("t5_ready", 32'(req_ready), 32'h2);
      req_valid = 2'b00;
      sync_phase(2);
      check("t5_words", 32'({wordA, wordB}), 32'h0);
      sync_phase(6);
      check("t5_ren", 32'({ReadEn, WriteEn}), 32'h2);
      sync_phase(9);
      check("t5_rsp_valid", 32'(rsp_valid), 32'h2);
      check("t5_rdata1", 32'(rsp_rdata[WIDTH +: WIDTH]), 32'h0);
      check("t5_rdata0_hold", 32'(rsp_rdata[0 +: WIDTH]), 32'hAAAA);

      // Reset between ph6 and ph8 of a port 0 read of row 4.
      req_valid = 2'b01; req_write = 2'b00; req_addr = {5'd0, 5'd4};
      sync_phase(0);
      check("t6_ready", 32'(req_ready), 32'h1);
      req_valid = 2'b00;
      sync_phase(6);
      check("t6_ren_before", 32'({ReadEn, WriteEn}), 32'h2);
      check("t6_wordA_before", 32'(wordA), 32'h10);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("t6_rst_en", 32'({ReadEn, WriteEn}), 32'h0);
      check("t6_rst_words", 32'({wordA, wordB}), 32'h0);
      check("t6_rst_din_rdata", 32'({din, rsp_rdata}), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      sync_phase(9);
      check("t6_no_rsp", 32'(rsp_valid), 32'h0);
      check("t6_en_idle", 32'({ReadEn, WriteEn}), 32'h0);
      req_valid = 2'b10; req_write = 2'b00; req_addr = {5'd5, 5'd0};
      sync_phase(0);
      check("t6_next_ready", 32'(req_ready), 32'h2);
      req_valid = 2'b00;
      sync_phase(9);
      check("t6_next_valid", 32'(rsp_valid), 32'h2);
      check("t6_next_rdata1", 32'(rsp_rdata[WIDTH +: WIDTH]), 32'h2222);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
